// File: rtl/esm_issue_queue.sv
// esm_issue_queue
//   Issue-queue front end for the ESM core. Accepts fetched instructions over a
//   valid/ready handshake, allocates each a buffer slot, writes it into the
//   core's dependency analyser, then issues independent instructions downstream
//   in round-robin order.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous clear of all slots and the issue register
//   fetch_valid/instr   fetch request; fetch_ready = a FREE slot exists
//   Instr_in, buffer_index, alloc_we
//                       registered write into the core, qualified by alloc_we
//   valid_entries       bit i set when slot i is VALID (bit 0 is the MSB)
//   independent_instr   from the core, bit i set when slot i has no dependence
//   issue_valid/instr/index, issue_ready
//                       downstream issue register and handshake
module esm_issue_queue #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             fetch_valid,
    input  logic [Instruction_word_size-1:0] fetch_instr,
    output logic                             fetch_ready,
    output logic [Instruction_word_size-1:0] Instr_in,
    output logic [$clog2(bs)-1:0]            buffer_index,
    output logic                             alloc_we,
    output logic [0:bs-1]                    valid_entries,
    input  logic [0:bs-1]                    independent_instr,
    output logic                             issue_valid,
    output logic [Instruction_word_size-1:0] issue_instr,
    output logic [$clog2(bs)-1:0]            issue_index,
    input  logic                             issue_ready
);

    localparam int W  = Instruction_word_size;
    localparam int IW = $clog2(bs);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        VALID   = 2'd2,
        ISSUING = 2'd3
    } slot_e;

    slot_e          slot_q   [bs];
    slot_e          slot_d   [bs];
    logic [W-1:0]   sinstr_q [bs];
    logic [W-1:0]   sinstr_d [bs];

    logic           alloc_we_q, alloc_we_d;
    logic [W-1:0]   instr_in_q, instr_in_d;
    logic [IW-1:0]  buf_idx_q, buf_idx_d;
    logic           issue_valid_q, issue_valid_d;
    logic [W-1:0]   issue_instr_q, issue_instr_d;
    logic [IW-1:0]  issue_index_q, issue_index_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;

    logic           free_any;
    logic [IW-1:0]  alloc_idx;
    logic [0:bs-1]  cand;
    logic           sel_found;
    logic [IW-1:0]  sel_idx;
    logic [IW-1:0]  probe;
    logic           accept, load, handshake;

    // Lowest-index FREE slot, and per-slot VALID visibility to the core.
    always_comb begin
        free_any      = 1'b0;
        alloc_idx     = '0;
        valid_entries = '0;
        for (int unsigned i = 0; i < bs; i++) begin
            valid_entries[i] = (slot_q[i] == VALID);
            if (slot_q[i] == FREE && !free_any) begin
                free_any  = 1'b1;
                alloc_idx = IW'(i);
            end
        end
    end

    // Round-robin search starting at rr_ptr; the IW-bit add wraps at bs
    // because bs is a power of two.
    always_comb begin
        cand      = valid_entries & independent_instr;
        sel_found = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int unsigned k = 0; k < bs; k++) begin
            probe = rr_ptr_q + IW'(k);
            if (!sel_found && cand[probe]) begin
                sel_found = 1'b1;
                sel_idx   = probe;
            end
        end
    end

    assign fetch_ready = free_any;
    assign accept      = fetch_valid & free_any & ~flush;
    assign handshake   = issue_valid_q & issue_ready;
    assign load        = (~issue_valid_q | issue_ready) & sel_found;

    always_comb begin
        slot_d   = slot_q;
        sinstr_d = sinstr_q;
        for (int unsigned i = 0; i < bs; i++) begin
            case (slot_q[i])
                FREE: begin
                    if (accept && alloc_idx == IW'(i)) begin
                        slot_d[i]   = PENDING;
                        sinstr_d[i] = fetch_instr;
                    end
                end
                PENDING: slot_d[i] = VALID;
                VALID:   if (load && sel_idx == IW'(i)) slot_d[i] = ISSUING;
                ISSUING: if (handshake && issue_index_q == IW'(i)) slot_d[i] = FREE;
                default: slot_d[i] = FREE;
            endcase
            if (flush) slot_d[i] = FREE;
        end
    end

    always_comb begin
        alloc_we_d    = accept;
        instr_in_d    = instr_in_q;
        buf_idx_d     = buf_idx_q;
        issue_valid_d = issue_valid_q;
        issue_instr_d = issue_instr_q;
        issue_index_d = issue_index_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept) begin
            instr_in_d = fetch_instr;
            buf_idx_d  = alloc_idx;
        end
        if (flush) begin
            issue_valid_d = 1'b0;
            rr_ptr_d      = '0;
        end else if (load) begin
            issue_valid_d = 1'b1;
            issue_instr_d = sinstr_q[sel_idx];
            issue_index_d = sel_idx;
            rr_ptr_d      = sel_idx + 1'b1;
        end else if (handshake) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < bs; i++) begin
                slot_q[i]   <= FREE;
                sinstr_q[i] <= '0;
            end
            alloc_we_q    <= 1'b0;
            instr_in_q    <= '0;
            buf_idx_q     <= '0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            issue_index_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            slot_q        <= slot_d;
            sinstr_q      <= sinstr_d;
            alloc_we_q    <= alloc_we_d;
            instr_in_q    <= instr_in_d;
            buf_idx_q     <= buf_idx_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_index_q <= issue_index_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign alloc_we     = alloc_we_q;
    assign Instr_in     = instr_in_q;
    assign buffer_index = buf_idx_q;
    assign issue_valid  = issue_valid_q;
    assign issue_instr  = issue_instr_q;
    assign issue_index  = issue_index_q;

endmodule

// File: tb/tb_esm_issue_queue.sv
// Directed testbench for esm_issue_queue (32-bit instructions, 16 slots).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_esm_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic [31:0] Instr_in;
    logic [3:0]  buffer_index;
    logic        alloc_we;
    logic [0:15] valid_entries;
    logic [0:15] independent_instr;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [3:0]  issue_index;
    logic        issue_ready;

    int n_checks = 0;
    int n_fail   = 0;

    esm_issue_queue #(
        .Instruction_word_size(32),
        .bs                   (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .fetch_valid      (fetch_valid),
        .fetch_instr      (fetch_instr),
        .fetch_ready      (fetch_ready),
        .Instr_in         (Instr_in),
        .buffer_index     (buffer_index),
        .alloc_we         (alloc_we),
        .valid_entries    (valid_entries),
        .independent_instr(independent_instr),
        .issue_valid      (issue_valid),
        .issue_instr      (issue_instr),
        .issue_index      (issue_index),
        .issue_ready      (issue_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        flush             = 1'b0;
        fetch_valid       = 1'b0;
        fetch_instr       = '0;
        independent_instr = '0;
        issue_ready       = 1'b0;

        // Reset state
        #12;
        check("rst_fetch_ready", fetch_ready, 1);
        check("rst_alloc_we", alloc_we, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_valid_entries", valid_entries, 0);
        check("rst_Instr_in", Instr_in, 0);
        check("rst_buffer_index", buffer_index, 0);
        check("rst_issue_instr", issue_instr, 0);
        check("rst_issue_index", issue_index, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: single instruction latency
        fetch_valid       = 1'b1;
        fetch_instr       = 32'hA000_000A;
        independent_instr = 16'hFFFF;
        issue_ready       = 1'b1;
        step();
        fetch_valid = 1'b0;
        check("t1_alloc_we", alloc_we, 1);
        check("t1_buffer_index", buffer_index, 0);
        check("t1_Instr_in", Instr_in, 32'hA000_000A);
        check("t1_valid_pending", valid_entries, 16'h0000);
        step();
        check("t1_valid_entries", valid_entries, 16'h8000);
        check("t1_alloc_we_drop", alloc_we, 0);
        check("t1_issue_not_yet", issue_valid, 0);
        step();
        check("t1_issue_valid", issue_valid, 1);
        check("t1_issue_index", issue_index, 0);
        check("t1_issue_instr", issue_instr, 32'hA000_000A);
        check("t1_issuing_hidden", valid_entries, 16'h0000);
        step();
        check("t1_issue_done", issue_valid, 0);
        check("t1_fetch_ready", fetch_ready, 1);

        // 2: fill all 16 slots back to back (rr_ptr is now 1)
        independent_instr = '0;
        fetch_valid       = 1'b1;
        for (int k = 0; k < 16; k++) begin
            fetch_instr = 32'h100 + k;
            step();
            check("t2_alloc_we", alloc_we, 1);
            check("t2_buffer_index", buffer_index, k);
            check("t2_Instr_in", Instr_in, 32'h100 + k);
        end
        check("t2_full_not_ready", fetch_ready, 0);
        fetch_instr = 32'hDEAD;
        step();
        fetch_valid = 1'b0;
        check("t2_17th_ignored", alloc_we, 0);
        check("t2_full_valid", valid_entries, 16'hFFFF);
        check("t2_still_full", fetch_ready, 0);

        // 5: handshake from a full queue frees a slot one cycle later
        independent_instr = 16'h0400;           // slot 5 only
        step();
        check("t5_issue_index", issue_index, 5);
        check("t5_issue_instr", issue_instr, 32'h105);
        check("t5_ready_cycleN", fetch_ready, 0);
        independent_instr = '0;
        step();
        check("t5_issue_drop", issue_valid, 0);
        check("t5_ready_cycleN1", fetch_ready, 1);
        fetch_valid = 1'b1;
        fetch_instr = 32'h205;
        step();
        fetch_valid = 1'b0;
        check("t5_reuse_index", buffer_index, 5);
        check("t5_reuse_we", alloc_we, 1);
        step();
        check("t5_full_again", valid_entries, 16'hFFFF);
        check("t5_not_ready", fetch_ready, 0);

        // 3: slots 2, 5, 14 independent with rr_ptr = 6
        independent_instr = 16'h2402;
        step();
        check("t3_first_index", issue_index, 14);
        check("t3_first_instr", issue_instr, 32'h10E);
        step();
        check("t3_second_index", issue_index, 2);
        check("t3_second_instr", issue_instr, 32'h102);
        step();
        check("t3_third_index", issue_index, 5);
        check("t3_third_instr", issue_instr, 32'h205);
        // rr_ptr must be 6 now: among slots 3 and 7 the pick is 7
        independent_instr = 16'h1100;
        step();
        check("t3_rr_index", issue_index, 7);
        check("t3_rr_instr", issue_instr, 32'h107);

        // 4: stall for 5 cycles
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_hold_valid", issue_valid, 1);
            check("t4_hold_index", issue_index, 7);
            check("t4_hold_instr", issue_instr, 32'h107);
            check("t4_hold_entries", valid_entries, 16'hDAFD);
        end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("t4_next_index", issue_index, 3);
        check("t4_next_instr", issue_instr, 32'h103);
        check("t4_entries", valid_entries, 16'hCAFD);
        check("t4_fetch_ready", fetch_ready, 1);
        fetch_valid = 1'b1;
        fetch_instr = 32'h302;
        step();
        check("t4_realloc_a", buffer_index, 2);
        fetch_instr = 32'h305;
        step();
        check("t4_realloc_b", buffer_index, 5);
        fetch_instr = 32'h307;
        step();
        check("t4_realloc_freed", buffer_index, 7);
        check("t4_realloc_instr", Instr_in, 32'h307);
        fetch_valid = 1'b0;

        // 6a: flush with a busy queue and a held issue
        check("t6_pre_issue", issue_valid, 1);
        flush       = 1'b1;
        fetch_valid = 1'b1;
        fetch_instr = 32'hBAD;
        check("t6_ready_in_flush", fetch_ready, 1);
        step();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        check("t6_flush_entries", valid_entries, 0);
        check("t6_flush_issue", issue_valid, 0);
        check("t6_flush_ready", fetch_ready, 1);
        check("t6_flush_we", alloc_we, 0);

        independent_instr = 16'hFFFF;
        fetch_valid       = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fetch_instr = 32'h400 + k;
            step();
            check("t6_post_flush_index", buffer_index, k);
        end
        fetch_valid = 1'b0;
        step();
        check("t6_busy_issue", issue_valid, 1);
        check("t6_busy_index", issue_index, 0);
        check("t6_busy_instr", issue_instr, 32'h400);
        check("t6_busy_entries", valid_entries, 16'h7F00);

        // 6b: asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_entries", valid_entries, 0);
        check("t6_rst_issue", issue_valid, 0);
        check("t6_rst_ready", fetch_ready, 1);
        check("t6_rst_index", issue_index, 0);
        check("t6_rst_instr", issue_instr, 0);
        #1;
        rst = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 32'h555;
        step();
        fetch_valid = 1'b0;
        check("t6_post_rst_index", buffer_index, 0);
        check("t6_post_rst_we", alloc_we, 1);
        check("t6_post_rst_instr", Instr_in, 32'h555);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/esm_issue_queue.md
# esm_issue_queue

Issue-queue front end for the ESM core. It accepts fetched instructions through a valid/ready handshake and allocates each one a buffer slot. It writes the instruction into the core's dependency analyser by driving `Instr_in`, `buffer_index` and `valid_entries`. It then consumes the analyser's `independent_instr` vector and issues ready instructions downstream in round-robin order. The block sits between fetch and the ESM core, and between the ESM core and execute.

## Interface

**Parameters**

- `Instruction_word_size`, 32, instruction width in bits.
- `bs`, 16, number of buffer slots. Must be a power of two, ≥2.

**Ports**

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all slots and the issue register.
- `fetch_valid`  in  1  fetch presents an instruction.
- `fetch_instr`  in  `Instruction_word_size`  fetched instruction.
- `fetch_ready`  out  1  a FREE slot exists; combinational from slot state.
- `Instr_in`  out  `Instruction_word_size`  instruction written to the core; registered.
- `buffer_index`  out  `$clog2(bs)`  slot being written; registered.
- `alloc_we`  out  1  one-cycle strobe qualifying `Instr_in` and `buffer_index`.
- `valid_entries`  out  [0:bs-1]  bit i = 1 when slot i is VALID.
- `independent_instr`  in  [0:bs-1]  from the core; bit i = 1 when slot i has no outstanding dependence.
- `issue_valid`  out  1  issue register holds an instruction.
- `issue_instr`  out  `Instruction_word_size`  issued instruction.
- `issue_index`  out  `$clog2(bs)`  slot of the issued instruction.
- `issue_ready`  in  1  execute accepts the instruction.

## Operation

**Slot state machine.** Each slot holds a 2-bit state plus a local copy of its instruction. The states are FREE, PENDING, VALID and ISSUING.

- FREE→PENDING: on a fetch accept (`fetch_valid & fetch_ready`), the lowest-index FREE slot moves to PENDING and the local copy is loaded.
- PENDING→VALID: happens unconditionally one cycle later, the edge after the `alloc_we` cycle.
- VALID→ISSUING: happens when the slot is selected into the issue register.
- ISSUING→FREE: happens on the issue handshake (`issue_valid & issue_ready`).

**Outputs derived from slot state**

- `fetch_ready` = OR of FREE over all slots.
- `valid_entries[i]` = (state_i == VALID). PENDING and ISSUING slots are never visible to the core.

**Issue select**

- Candidates: `valid_entries & independent_instr`.
- The register loads when it is empty or handshaking this cycle (`!issue_valid | issue_ready`) and at least one candidate exists.
- The chosen slot is the first candidate at or after `rr_ptr`, searching upward modulo `bs`.
- On load, `rr_ptr` ← (chosen index + 1) mod `bs`, with natural wrap from `bs`-1 to 0.
- On a handshake with no candidate, `issue_valid` drops to 0.
- `issue_valid`, `issue_instr` and `issue_index` are held stable until the handshake.

**Flush**

- All slots go to FREE, and `issue_valid`, `alloc_we` and `rr_ptr` go to 0.
- Flush has priority over every same-cycle accept, select or handshake.
- `fetch_ready` stays combinational, so it can be 1 during the flush cycle. An accept in that cycle is discarded.

## Timing

**Reset.** While `rst` is asserted:

- All slots are FREE.
- `alloc_we`, `issue_valid` and `valid_entries` are 0.
- `Instr_in`, `issue_instr`, `buffer_index`, `issue_index` and `rr_ptr` are 0.
- `fetch_ready` = 1.

Asserting reset mid-operation abandons all in-flight state, including any held issue, immediately.

**Write path, for an accept in cycle N**

- Cycle N+1: `alloc_we` = 1, with `Instr_in` and `buffer_index` valid; the slot is PENDING.
- Cycle N+2: `valid_entries` bit set.
- With back-to-back accepts, `alloc_we` is asserted on consecutive cycles.

**Issue latency**

- Minimum fetch-accept to `issue_valid` is 3 cycles, given the core's `independent_instr` is combinational on `valid_entries`.
- Sustained throughput is one issue per cycle while `issue_ready` = 1.

**Simultaneous events**

- A slot freed by a handshake in cycle N is allocatable from cycle N+1. `fetch_ready` is never computed from next-state.
- Accept, select and handshake in the same cycle all take effect at the same edge.

**Full queue**

- All slots non-FREE ⇒ `fetch_ready` = 0, and `fetch_instr` is ignored.

**Width rules**

- `buffer_index`, `issue_index` and `rr_ptr` are `$clog2(bs)` bits.
- The round-robin search wraps without a carry bit.

## Test plan

1. Reset, then accept A in cycle 1 with `independent_instr` all-ones, `issue_ready` = 1.
   - Cycle 2: `alloc_we` = 1, `buffer_index` = 0.
   - Cycle 3: `valid_entries` = 1000…0.
   - Cycle 4: `issue_valid` = 1, `issue_index` = 0, `issue_instr` = A.
2. 16 back-to-back accepts with `independent_instr` = 0.
   - `buffer_index` 0..15 on consecutive cycles.
   - `fetch_ready` = 0 after the 16th accept.
   - A 17th `fetch_valid` is ignored.
3. Slots 2, 5 and 14 independent, `rr_ptr` = 6, `issue_ready` = 1.
   - Issues in order 14, 2, 5.
   - `rr_ptr` ends at 6.
4. Hold `issue_ready` = 0 for 5 cycles.
   - `issue_instr` and `issue_index` stay constant.
   - Slot stays ISSUING, with its `valid_entries` bit 0.
   - When `issue_ready` rises, that slot is FREE and reallocatable the next cycle.
5. Queue full, then a handshake in cycle N.
   - `fetch_ready` = 0 in cycle N and 1 in cycle N+1.
   - The next accept reuses the freed index.
6. Assert `flush`, or asynchronous `rst` mid-cycle, with 8 slots busy and `issue_valid` = 1.
   - Next edge (`flush`), or immediately (`rst`): `valid_entries` = 0, `issue_valid` = 0, `fetch_ready` = 1.
   - First post-clear allocation uses slot 0.
